nrzi_rx_unstuff: RTL
====================

// Module: nrzi_rx_unstuff
// PURPOSE
//  Receive-side line decoder for the USB bit-level path; counterpart of the transmit NRZI encoder.
//  Samples dp/dm once per bit-clock and classifies each sample as J, K, SE0 or SE1.
//  Hunts for SYNC, NRZI-decodes, removes stuffed bits, detects EOP and flags line errors.
//  Emits one qualified data bit per cycle to the downstream packet/CRC receiver.
// PARAMETERS
//  STUFF_LEN  6  consecutive decoded 1s after which the next bit must be a stuffed 0
//  SYNC_MIN   7  decoded 0s required before the terminating 1 of SYNC (7 = full KJKJKJKK)
// PORTS
//  clk        in   1  bit-rate clock
//  rst        in   1  synchronous reset, active-high
//  dp         in   1  D+ line sample
//  dm         in   1  D- line sample
//  recving    in   1  receive enable; low = ignore line and abort any packet
//  outb       out  1  decoded, unstuffed data bit (valid only when bit_valid)
//  bit_valid  out  1  outb carries a payload bit this cycle
//  sending    out  1  high while in DATA (packet body in progress)
//  sop        out  1  1-cycle pulse: SYNC accepted
//  eop        out  1  1-cycle pulse: valid EOP (SE0,SE0,J) completed
//  stuff_err  out  1  1-cycle pulse: 1 received where a stuffed 0 was required
//  rx_err     out  1  1-cycle pulse: any error or abort (includes stuff_err cases)
// BEHAVIOUR
//  Line symbols: J = dp1/dm0; K = dp0/dm1; SE0 = 00; SE1 = 11 (always illegal).
//  NRZI decode: bit = 1 if the symbol equals prev_level, 0 on a J<->K change.
//   prev_level updates on every J/K sample. It is set to J on reset, on entry to HUNT, and on eop.
//  Outputs are registered. A symbol present in cycle t produces its result in cycle t+1.
//   All pulses last exactly 1 cycle.
//  Reset: state=HUNT, prev_level=J, counters 0, all outputs 0. Reset takes priority everywhere.
//   Reset mid-packet aborts silently (no rx_err).
//  FSM states:
//   HUNT: zero_cnt saturates at SYNC_MIN.
//    - decoded 0: zero_cnt++
//    - decoded 1 with zero_cnt>=SYNC_MIN: go to DATA, pulse sop, ones_cnt=1 (the SYNC 1 counts toward stuffing)
//    - decoded 1 with zero_cnt<SYNC_MIN: zero_cnt=0, stay in HUNT
//    - SE0/SE1: zero_cnt=0, stay in HUNT (no error)
//   DATA: sending=1.
//    - J/K with ones_cnt==STUFF_LEN, decoded 0: bit dropped (bit_valid=0), ones_cnt=0
//    - J/K with ones_cnt==STUFF_LEN, decoded 1: stuff_err+rx_err, go to ERR
//    - J/K otherwise: bit_valid=1, outb=bit; ones_cnt = bit ? ones_cnt+1 : 0
//    - SE0: go to EOP1 (no bit). SE1: rx_err, go to ERR.
//   EOP1: SE0 goes to EOP2. Anything else: rx_err, go to ERR.
//   EOP2: J pulses eop, goes to HUNT (prev_level=J, zero_cnt=0). K, SE0 or SE1: rx_err, go to ERR.
//   ERR: outputs idle. Stays until a J is sampled with recving=1, then goes to HUNT.
//  recving=0: next state HUNT and counters cleared.
//   From DATA/EOP1/EOP2 this also pulses rx_err. From HUNT/ERR it pulses nothing.
//  Stuff check precedes data: a stuffed 0 is never presented, even if it is the last bit before SE0.
//  SE0 arriving while ones_cnt==STUFF_LEN is legal EOP (no stuff_err).
//  sending drops in the same cycle eop or rx_err pulses.
//   bit_valid is never asserted in the same cycle as sop, eop or rx_err.
// TESTING
//  1. Idle J, then KJKJKJKK, then data 0xA5 LSB-first, then SE0,SE0,J:
//     sop once; bits 1,0,1,0,0,1,0,1 with bit_valid; then eop once, rx_err=0.
//  2. SYNC, then data 0x7F,0x80 with a stuffed 0 after six 1s (SYNC 1 counts):
//     16 valid bits, stuffed bit dropped, no stuff_err.
//  3. SYNC, then seven decoded 1s without a stuffed 0: stuff_err+rx_err on the 7th-bit cycle; ERR until J.
//  4. SYNC, data, then a single SE0 followed by K: rx_err, no eop; a SYNC after J is accepted again.
//  5. recving drops mid-byte: rx_err pulse, sending=0 next cycle; a SYNC with only 5 leading 0s is ignored (no sop).
//  6. rst asserted in DATA: all outputs 0 next cycle, no rx_err; the following full SYNC gives sop.

Source files
------------

// File: rtl/nrzi_rx_unstuff.sv
// rtl/nrzi_rx_unstuff.sv - USB receive path: SYNC hunt, NRZI decode, bit unstuffing, EOP and line-error detection.
module nrzi_rx_unstuff #(
  parameter int STUFF_LEN = 6,
  parameter int SYNC_MIN  = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic dp,
  input  logic dm,
  input  logic recving,
  output logic outb,
  output logic bit_valid,
  output logic sending,
  output logic sop,
  output logic eop,
  output logic stuff_err,
  output logic rx_err
);

  localparam int ZW = $clog2(SYNC_MIN + 1);
  localparam int OW = $clog2(STUFF_LEN + 1);

  typedef enum logic [2:0] {
    S_HUNT,
    S_DATA,
    S_EOP1,
    S_EOP2,
    S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic          prev_q, prev_d;
  logic [ZW-1:0] zero_q, zero_d;
  logic [OW-1:0] ones_q, ones_d;
  logic          outb_q, outb_d;
  logic          valid_q, valid_d;
  logic          sending_q, sending_d;
  logic          sop_q, sop_d;
  logic          eop_q, eop_d;
  logic          serr_q, serr_d;
  logic          rxerr_q, rxerr_d;

  logic is_j, is_jk, is_se0, is_se1, dec_bit;

  // prev_q holds the last J/K level as dp (1 = J).
  assign is_j    = dp & ~dm;
  assign is_jk   = dp ^ dm;
  assign is_se0  = ~dp & ~dm;
  assign is_se1  = dp & dm;
  assign dec_bit = (dp == prev_q);

  always_comb begin
    state_d = state_q;
    prev_d  = is_jk ? dp : prev_q;
    zero_d  = zero_q;
    ones_d  = ones_q;
    outb_d  = 1'b0;
    valid_d = 1'b0;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    serr_d  = 1'b0;
    rxerr_d = 1'b0;

    if (!recving) begin
      rxerr_d = (state_q == S_DATA) || (state_q == S_EOP1) || (state_q == S_EOP2);
      state_d = S_HUNT;
      prev_d  = 1'b1;
      zero_d  = '0;
      ones_d  = '0;
    end else begin
      case (state_q)
        S_HUNT: begin
          if (!is_jk) begin
            zero_d = '0;
          end else if (!dec_bit) begin
            zero_d = (zero_q >= ZW'(SYNC_MIN)) ? zero_q : zero_q + ZW'(1);
          end else if (zero_q >= ZW'(SYNC_MIN)) begin
            state_d = S_DATA;
            sop_d   = 1'b1;
            zero_d  = '0;
            ones_d  = OW'(1);
          end else begin
            zero_d = '0;
          end
        end
        S_DATA: begin
          if (is_se0) begin
            state_d = S_EOP1;
          end else if (is_se1) begin
            rxerr_d = 1'b1;
            state_d = S_ERR;
            ones_d  = '0;
          end else if (ones_q == OW'(STUFF_LEN)) begin
            // Stuffed position: a 0 is swallowed, a 1 breaks the stuffing rule.
            ones_d = '0;
            if (dec_bit) begin
              serr_d  = 1'b1;
              rxerr_d = 1'b1;
              state_d = S_ERR;
            end
          end else begin
            valid_d = 1'b1;
            outb_d  = dec_bit;
            ones_d  = dec_bit ? ones_q + OW'(1) : '0;
          end
        end
        S_EOP1: begin
          if (is_se0) begin
            state_d = S_EOP2;
          end else begin
            rxerr_d = 1'b1;
            state_d = S_ERR;
          end
          ones_d = '0;
        end
        S_EOP2: begin
          if (is_j) begin
            eop_d   = 1'b1;
            state_d = S_HUNT;
            prev_d  = 1'b1;
            zero_d  = '0;
          end else begin
            rxerr_d = 1'b1;
            state_d = S_ERR;
          end
          ones_d = '0;
        end
        default: begin
          if (is_j) begin
            state_d = S_HUNT;
            prev_d  = 1'b1;
            zero_d  = '0;
            ones_d  = '0;
          end
        end
      endcase
    end

    sending_d = (state_d == S_DATA) || (state_d == S_EOP1) || (state_d == S_EOP2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_HUNT;
      prev_q    <= 1'b1;
      zero_q    <= '0;
      ones_q    <= '0;
      outb_q    <= 1'b0;
      valid_q   <= 1'b0;
      sending_q <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      serr_q    <= 1'b0;
      rxerr_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      zero_q    <= zero_d;
      ones_q    <= ones_d;
      outb_q    <= outb_d;
      valid_q   <= valid_d;
      sending_q <= sending_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
      serr_q    <= serr_d;
      rxerr_q   <= rxerr_d;
    end
  end

  assign outb      = outb_q;
  assign bit_valid = valid_q;
  assign sending   = sending_q;
  assign sop       = sop_q;
  assign eop       = eop_q;
  assign stuff_err = serr_q;
  assign rx_err    = rxerr_q;

endmodule
